// File: rtl/dma_cfg_pkg.sv
// Shared definitions for the DMA configuration AXI-Lite write master:
// register word indices, FSM states, AXI response and error encodings.
package dma_cfg_pkg;

  localparam logic [1:0] REG_SRC   = 2'd0;
  localparam logic [1:0] REG_DEST  = 2'd1;
  localparam logic [1:0] REG_LEN   = 2'd2;
  localparam logic [1:0] REG_START = 2'd3;

  localparam logic [31:0] START_WORD = 32'h0000_0001;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_e;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_BRESP   = 2'd1,
    ERR_TIMEOUT = 2'd2
  } err_code_e;

endpackage

// File: rtl/dma_axil_cfg_master.sv
// AXI-Lite master writing SRC, DEST, LEN, START to the DMA register block per command.
// Optional per-write watchdog enabled by defining DMA_CFG_TIMEOUT_EN.
module dma_axil_cfg_master
  import dma_cfg_pkg::*;
#(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR      = '0,
  parameter int                TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [31:0]       cmd_src,
  input  logic [31:0]       cmd_dest,
  input  logic [31:0]       cmd_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  input  logic              m_axi_bvalid,
  input  logic [1:0]        m_axi_bresp,
  output logic              m_axi_bready
);

  // Handshake rule on every channel: a transfer happens on a rising clk edge
  // where valid and ready are both high; valid and its payload hold until then.

  state_e    state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [31:0] src_q, dest_q, len_q;
  logic      aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic      err_q, err_d;
  err_code_e err_code_q, err_code_d;
  logic      load_cmd;
  logic      aw_hs, w_hs;
  logic      wd_expired;
  logic [31:0] wdata_sel;

  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid & m_axi_wready;

`ifdef DMA_CFG_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q;

  assign wd_expired = ((state_q == ST_WR) || (state_q == ST_RESP)) &&
                      (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  // Restart on every entry into WR so each register write gets its own budget.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd_q <= '0;
    end else if ((state_d == ST_WR) && (state_q != ST_WR)) begin
      wd_q <= '0;
    end else if ((state_q == ST_WR) || (state_q == ST_RESP)) begin
      wd_q <= wd_q + 1'b1;
    end else begin
      wd_q <= '0;
    end
  end
`else
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    load_cmd   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          load_cmd   = 1'b1;
          idx_d      = REG_SRC;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
          state_d    = (cmd_len == 32'd0) ? ST_DONE : ST_WR;
        end
      end
      ST_WR: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi_bvalid) begin
          if (resp_e'(m_axi_bresp) == RESP_OKAY) begin
            if (idx_q == REG_START) begin
              state_d = ST_DONE;
            end else begin
              idx_d   = idx_q + 2'd1;
              state_d = ST_WR;
            end
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_BRESP;
            state_d    = ST_DONE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // A write that completes on its last allowed cycle still counts as progress.
    if (wd_expired && (state_d == state_q)) begin
      aw_done_d  = 1'b0;
      w_done_d   = 1'b0;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = ST_DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= REG_SRC;
      src_q      <= '0;
      dest_q     <= '0;
      len_q      <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      if (load_cmd) begin
        src_q  <= cmd_src;
        dest_q <= cmd_dest;
        len_q  <= cmd_len;
      end
    end
  end

  always_comb begin
    wdata_sel = START_WORD;
    unique case (idx_q)
      REG_SRC:  wdata_sel = src_q;
      REG_DEST: wdata_sel = dest_q;
      REG_LEN:  wdata_sel = len_q;
      default:  wdata_sel = START_WORD;
    endcase
  end

  // Address and data are driven only in WR so the bus reads zero when idle.
  assign m_axi_awaddr  = (state_q == ST_WR) ?
                         (BASE_ADDR + {{(ADDR_W-4){1'b0}}, idx_q, 2'b00}) : '0;
  assign m_axi_wdata   = (state_q == ST_WR) ? DATA_W'(wdata_sel) : '0;
  assign m_axi_awvalid = (state_q == ST_WR) && !aw_done_q;
  assign m_axi_wvalid  = (state_q == ST_WR) && !w_done_q;
  assign m_axi_bready  = (state_q == ST_RESP);

  assign cmd_ready = rst_n && (state_q == ST_IDLE);
  assign busy      = (state_q == ST_WR) || (state_q == ST_RESP);
  assign done      = (state_q == ST_DONE);
  assign err       = err_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_dma_axil_cfg_master.sv
// Directed bench for dma_axil_cfg_master: AXI-Lite slave model, write scoreboard,
// latency/error checks. Build with DMA_CFG_TIMEOUT_EN to exercise the watchdog.
module tb_dma_axil_cfg_master;

  localparam int          TO   = 16;
  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [31:0] cmd_src = '0, cmd_dest = '0, cmd_len = '0;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [31:0] m_axi_awaddr, m_axi_wdata;
  logic        m_axi_awvalid, m_axi_wvalid, m_axi_bready;
  logic        m_axi_awready = 1'b0, m_axi_wready = 1'b0, m_axi_bvalid = 1'b0;
  logic [1:0]  m_axi_bresp = 2'b00;

  dma_axil_cfg_master #(
    .ADDR_W(32), .DATA_W(32), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_dest(cmd_dest), .cmd_len(cmd_len),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bresp(m_axi_bresp), .m_axi_bready(m_axi_bready)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- counters and scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [63:0] exp_q[$];
  logic [31:0] aw_obs[$];
  logic [31:0] w_obs[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int   aw_delay = 0, w_delay = 0, b_delay = 0;
  bit   b_never = 0, spur_b = 0, err_en = 0;
  logic [31:0] err_addr = '0;
  logic [31:0] last_aw_addr = '0;
  int   aw_cnt = 0, w_cnt = 0, b_cnt = 0;

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_bvalid = spur_b;
      m_axi_bresp = 2'b00;
    end else begin
      aw_cnt = m_axi_awvalid ? aw_cnt + 1 : 0;
      w_cnt  = m_axi_wvalid ? w_cnt + 1 : 0;
      b_cnt  = m_axi_bready ? b_cnt + 1 : 0;
      m_axi_awready = m_axi_awvalid && (aw_cnt > aw_delay);
      m_axi_wready  = m_axi_wvalid && (w_cnt > w_delay);
      m_axi_bvalid  = spur_b || (m_axi_bready && !b_never && (b_cnt > b_delay));
      m_axi_bresp   = (err_en && (last_aw_addr == err_addr)) ? 2'b10 : 2'b00;
    end
  end

  // ---------------- monitor ----------------
  int   done_cnt = 0, done_cyc = 0, acc_cyc = 0;
  logic done_err, done_busy;
  logic [1:0] done_code;
  bit   aw_pend = 0, w_pend = 0;
  logic [31:0] aw_hold, w_hold;

  always @(negedge clk) begin
    if (rst_n) begin
      if (aw_pend) begin
        check("aw_held", m_axi_awvalid, 1);
        check("aw_stable", m_axi_awaddr, aw_hold);
      end
      if (w_pend) begin
        check("w_held", m_axi_wvalid, 1);
        check("w_stable", m_axi_wdata, w_hold);
      end
      if (w_obs.size() > aw_obs.size()) check("w_drop", m_axi_wvalid, 0);
      if (aw_obs.size() > w_obs.size()) check("aw_drop", m_axi_awvalid, 0);
      if (busy) check("ready_busy", cmd_ready, 0);
      if (m_axi_bready) check("bready_excl", {m_axi_awvalid, m_axi_wvalid}, 0);
      aw_pend = m_axi_awvalid && !m_axi_awready;
      w_pend  = m_axi_wvalid && !m_axi_wready;
      aw_hold = m_axi_awaddr;
      w_hold  = m_axi_wdata;
      if (m_axi_awvalid && m_axi_awready) begin
        aw_obs.push_back(m_axi_awaddr);
        last_aw_addr = m_axi_awaddr;
      end
      if (m_axi_wvalid && m_axi_wready) w_obs.push_back(m_axi_wdata);
      while (aw_obs.size() > 0 && w_obs.size() > 0) begin
        logic [63:0] got;
        got = {aw_obs.pop_front(), w_obs.pop_front()};
        if (exp_q.size() == 0) check("unexpected_write", got, 64'h0);
        else check("write", got, exp_q.pop_front());
      end
      if (cmd_valid && cmd_ready) acc_cyc = cyc;
      if (done) begin
        done_cnt++;
        done_cyc  = cyc;
        done_err  = err;
        done_code = err_code;
        done_busy = busy;
      end
    end else begin
      aw_pend = 0;
      w_pend  = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_cmd(input string tag, input logic [31:0] s, d, l);
    bit ok = 0;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_src = s; cmd_dest = d; cmd_len = l;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (cmd_ready) ok = 1;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    cmd_src = $urandom; cmd_dest = $urandom; cmd_len = $urandom;
    check({tag, "_accepted"}, ok, 1);
    check({tag, "_err_clr"}, {err, err_code}, 3'b000);
  endtask

  task automatic run_cmd(input string tag, input logic [31:0] s, d, l, input int n_exp,
                         input int exp_lat, input logic exp_err, input logic [1:0] exp_code,
                         input int limit);
    logic [31:0] vals[4];
    int base;
    bit got = 0;
    vals[0] = s; vals[1] = d; vals[2] = l; vals[3] = 32'h1;
    base = done_cnt;
    for (int i = 0; i < n_exp; i++) exp_q.push_back({BASE + 32'(4 * i), vals[i]});
    send_cmd(tag, s, d, l);
    for (int i = 0; i < limit && !got; i++) begin
      @(posedge clk); #2;
      if (done_cnt != base) got = 1;
    end
    check({tag, "_done_seen"}, got, 1);
    if (got) begin
      if (exp_lat >= 0) check({tag, "_latency"}, done_cyc - acc_cyc, exp_lat);
      check({tag, "_err"}, done_err, exp_err);
      check({tag, "_err_code"}, done_code, exp_code);
      check({tag, "_busy_at_done"}, done_busy, 0);
    end
    repeat (3) @(posedge clk);
    #2;
    check({tag, "_pending_writes"}, exp_q.size() + aw_obs.size() + w_obs.size(), 0);
    check({tag, "_done_pulses"}, done_cnt - base, 1);
    exp_q.delete(); aw_obs.delete(); w_obs.delete();
  endtask

  // Pulses rst_n low across exactly one rising edge and checks the reset state.
  task automatic reset_pulse(input string tag);
    int base = done_cnt;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #2;
    check({tag, "_outs_zero"},
          {cmd_ready, busy, done, err, err_code, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
           m_axi_awaddr, m_axi_wdata}, '0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check({tag, "_cmd_ready"}, cmd_ready, 1);
    check({tag, "_idle_outs"}, {busy, done, err, err_code}, 5'b0);
    repeat (3) @(posedge clk);
    #2;
    check({tag, "_no_done"}, done_cnt - base, 0);
    exp_q.delete(); aw_obs.delete(); w_obs.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    logic [31:0] s, d, l;

    repeat (3) @(posedge clk);
    #2;
    check("reset_outs",
          {cmd_ready, busy, done, err, err_code, m_axi_awvalid, m_axi_wvalid, m_axi_bready,
           m_axi_awaddr, m_axi_wdata}, '0);
    rst_n = 1'b1;
    @(posedge clk); #2;
    check("reset_cmd_ready", cmd_ready, 1);

    run_cmd("basic", 32'h1000, 32'h2000, 32'h40, 4, 9, 1'b0, 2'd0, 40);

    aw_delay = 3; w_delay = 0;
    run_cmd("split_aw", $urandom, $urandom, $urandom | 32'h1, 4, 21, 1'b0, 2'd0, 60);
    aw_delay = 0; w_delay = 2; b_delay = 1;
    run_cmd("split_w", $urandom, $urandom, $urandom | 32'h1, 4, 21, 1'b0, 2'd0, 60);
    w_delay = 0; b_delay = 0;

    err_en = 1; err_addr = BASE + 32'h4;
    run_cmd("slverr", 32'hA0, 32'hB0, 32'hC0, 2, 5, 1'b1, 2'd1, 40);
    err_en = 0;
    check("err_sticky", {err, err_code}, 3'b101);
    run_cmd("after_err", 32'h11, 32'h22, 32'h33, 4, 9, 1'b0, 2'd0, 40);

    run_cmd("zero_len", 32'h5555, 32'h6666, 32'h0, 0, 1, 1'b0, 2'd0, 10);

    spur_b = 1;
    run_cmd("spur_bvalid", $urandom, $urandom, 32'h80, 4, 9, 1'b0, 2'd0, 40);
    spur_b = 0;

    for (int k = 0; k < 3; k++) begin
      aw_delay = $urandom_range(0, 2);
      w_delay  = $urandom_range(0, 2);
      b_delay  = $urandom_range(0, 2);
      s = $urandom; d = $urandom; l = $urandom_range(1, 4096);
      run_cmd("random", s, d, l, 4, -1, 1'b0, 2'd0, 80);
    end
    aw_delay = 0; w_delay = 0; b_delay = 0;

    // Slave never answers B on the first write.
    b_never = 1;
`ifdef DMA_CFG_TIMEOUT_EN
    run_cmd("timeout", 32'h7000, 32'h8000, 32'h10, 1, TO + 1, 1'b1, 2'd2, 40);
    reset_pulse("post_timeout_reset");
`else
    base = done_cnt;
    exp_q.push_back({BASE, 32'h7000});
    send_cmd("hang", 32'h7000, 32'h8000, 32'h10);
    repeat (40) @(posedge clk);
    #2;
    check("hang_busy", {busy, m_axi_bready}, 2'b11);
    check("hang_no_done", done_cnt - base, 0);
    check("hang_no_timeout_code", err_code, 2'd0);
`endif

    // Reset while waiting for a write response.
`ifdef DMA_CFG_TIMEOUT_EN
    exp_q.push_back({BASE, 32'h9000});
    send_cmd("mid_resp", 32'h9000, 32'h9100, 32'h20);
    repeat (4) @(posedge clk);
    #2;
    check("mid_resp_bready", m_axi_bready, 1);
`endif
    reset_pulse("reset_mid_resp");
    b_never = 0;

    run_cmd("recovered", 32'hC000, 32'hD000, 32'h100, 4, 9, 1'b0, 2'd0, 40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
